// File: rtl/drum_pkg.sv
// Shared types for the drum-machine audio path: sample format and the
// UART byte-streamer state encoding.
package drum_pkg;

    typedef logic [7:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD_LOW,
        HOLD_HIGH
    } tx_state_t;

    localparam sample_t SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push at full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and level
    // define which entries are valid, and leaving it reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sample_tx_streamer.sv
// Decimates mixer samples into a FIFO and streams them as SYNC-framed bytes
// over the UART load/ready handshake.
module sample_tx_streamer
    import drum_pkg::*;
#(
    parameter int      DEPTH     = 16,
    parameter int      DECIM     = 4,
    parameter int      FRAME_LEN = 32,
    parameter sample_t SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sample_tick,
    input  logic [7:0]             sample_in,
    input  logic                   txready,
    output logic [7:0]             txdata,
    output logic                   txclk,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   busy
);

    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int FCW = $clog2(FRAME_LEN + 1);

    tx_state_t      state;
    tx_state_t      state_next;
    logic [DCW-1:0] decim_ctr;
    logic [FCW-1:0] frame_ctr;
    sample_t        tx_byte;
    logic           send_data;
    logic           enable_q;
    logic           overflow_q;

    logic           tick_ok;
    logic           flush;
    logic           start;
    logic           drop;
    logic           fifo_rst;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    sample_t        fifo_dout;

    assign tick_ok   = enable && sample_tick;
    assign fifo_push = tick_ok && (decim_ctr == '0);
    assign fifo_pop  = (state == SEND) && send_data;
    assign drop      = fifo_push && fifo_full && !fifo_pop;
    // Disabled and idle: discard the backlog so a re-enable starts a fresh frame.
    assign flush     = (state == IDLE) && !enable;
    assign fifo_rst  = rst || flush;
    // Every byte, SYNC included, needs queued data, so no empty headers go out.
    assign start     = (state == IDLE) && enable && txready && !fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sample_in),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch forms.
        state_next = state;
        case (state)
            IDLE:      if (start)    state_next = SEND;
            SEND:                    state_next = HOLD_LOW;
            HOLD_LOW:  if (!txready) state_next = HOLD_HIGH;
            HOLD_HIGH: if (txready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        txclk    = (state == SEND);
        busy     = (state != IDLE) || !fifo_empty;
        txdata   = tx_byte;
        overflow = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decim_ctr  <= '0;
            frame_ctr  <= '0;
            tx_byte    <= '0;
            send_data  <= 1'b0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            enable_q   <= enable;
            overflow_q <= (overflow_q && !(enable && !enable_q)) || drop;

            if (flush) begin
                decim_ctr <= '0;
                frame_ctr <= '0;
            end else begin
                if (tick_ok)
                    decim_ctr <= (decim_ctr == DCW'(DECIM - 1)) ? '0 : decim_ctr + 1'b1;
                if (state == SEND)
                    frame_ctr <= (frame_ctr == FCW'(FRAME_LEN)) ? '0 : frame_ctr + 1'b1;
            end

            // Byte is latched on entry to SEND and held until the next start.
            if (start) begin
                tx_byte   <= (frame_ctr == '0) ? SYNC_BYTE : fifo_dout;
                send_data <= (frame_ctr != '0);
            end
        end
    end

endmodule

// File: tb/tb_sample_tx_streamer.sv
// Scoreboard bench: dut_a (DECIM=1, FRAME_LEN=2) covers framing, overflow,
// full push/pop, enable drop and reset; dut_b (DECIM=4) covers decimation.
module tb_sample_tx_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, enable_a, tick_a_s, txready_a, txclk_a, overflow_a, busy_a;
    logic [7:0] sample_in_a, txdata_a;
    logic [4:0] level_a;
    logic       rst_b, enable_b, tick_b_s, txready_b, txclk_b, overflow_b, busy_b;
    logic [7:0] sample_in_b, txdata_b;
    logic [4:0] level_b;

    logic hold_a, hold_b, uart_busy_a, uart_busy_b;
    assign txready_a = !uart_busy_a && !hold_a;
    assign txready_b = !uart_busy_b && !hold_b;

    sample_tx_streamer #(.DEPTH(16), .DECIM(1), .FRAME_LEN(2), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst(rst_a), .enable(enable_a), .sample_tick(tick_a_s),
        .sample_in(sample_in_a), .txready(txready_a), .txdata(txdata_a),
        .txclk(txclk_a), .fifo_level(level_a), .overflow(overflow_a), .busy(busy_a)
    );

    sample_tx_streamer #(.DEPTH(16), .DECIM(4), .FRAME_LEN(32), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .sample_tick(tick_b_s),
        .sample_in(sample_in_b), .txready(txready_b), .txdata(txdata_b),
        .txclk(txclk_b), .fifo_level(level_b), .overflow(overflow_b), .busy(busy_b)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic       prev_clk_a = 1'b0;
    logic       prev_clk_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // UART model: after each load strobe, busy (txready low) for 3 clk.
    initial begin
        uart_busy_a = 1'b0;
        forever begin
            @(negedge clk);
            if (txclk_a) begin
                uart_busy_a = 1'b1;
                repeat (3) @(negedge clk);
                uart_busy_a = 1'b0;
            end
        end
    end

    initial begin
        uart_busy_b = 1'b0;
        forever begin
            @(negedge clk);
            if (txclk_b) begin
                uart_busy_b = 1'b1;
                repeat (3) @(negedge clk);
                uart_busy_b = 1'b0;
            end
        end
    end

    // Monitors: every load strobe pops one expected byte.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (txclk_a) begin
                check("txclk_a_gap", {31'd0, prev_clk_a}, 0);
                if (exp_a.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL txdata_a: got %0h expected none", txdata_a);
                end else begin
                    e = exp_a.pop_front();
                    check("txdata_a", {24'd0, txdata_a}, {24'd0, e});
                end
            end
            prev_clk_a = txclk_a;
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (txclk_b) begin
                check("txclk_b_gap", {31'd0, prev_clk_b}, 0);
                if (exp_b.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL txdata_b: got %0h expected none", txdata_b);
                end else begin
                    e = exp_b.pop_front();
                    check("txdata_b", {24'd0, txdata_b}, {24'd0, e});
                end
            end
            prev_clk_b = txclk_b;
        end
    end

    task automatic tick_a(input logic [7:0] v);
        sample_in_a = v;
        tick_a_s    = 1'b1;
        step();
        tick_a_s    = 1'b0;
    endtask

    task automatic tick_b(input logic [7:0] v);
        sample_in_b = v;
        tick_b_s    = 1'b1;
        step();
        tick_b_s    = 1'b0;
    endtask

    task automatic toggle_a();
        enable_a = 1'b0;
        step();
        step();
        enable_a = 1'b1;
        step();
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while ((exp_a.size() != 0 || busy_a) && n < 2000) begin
            step();
            n++;
        end
        check({name, "_queue"}, exp_a.size(), 0);
        check({name, "_busy"}, {31'd0, busy_a}, 0);
    endtask

    task automatic drain_b(input string name);
        int n = 0;
        while ((exp_b.size() != 0 || busy_b) && n < 2000) begin
            step();
            n++;
        end
        check({name, "_queue"}, exp_b.size(), 0);
        check({name, "_busy"}, {31'd0, busy_b}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] peak;
        logic       found;

        rst_a = 1'b1; enable_a = 1'b0; tick_a_s = 1'b0; sample_in_a = '0; hold_a = 1'b0;
        rst_b = 1'b1; enable_b = 1'b0; tick_b_s = 1'b0; sample_in_b = '0; hold_b = 1'b1;
        repeat (3) step();

        @(negedge clk);
        check("rst_txdata_a",   {24'd0, txdata_a}, 0);
        check("rst_txclk_a",    {31'd0, txclk_a}, 0);
        check("rst_level_a",    {27'd0, level_a}, 0);
        check("rst_overflow_a", {31'd0, overflow_a}, 0);
        check("rst_busy_a",     {31'd0, busy_a}, 0);
        check("rst_txdata_b",   {24'd0, txdata_b}, 0);
        check("rst_txclk_b",    {31'd0, txclk_b}, 0);
        check("rst_level_b",    {27'd0, level_b}, 0);
        check("rst_busy_b",     {31'd0, busy_b}, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Decimation: ticks 0..11, only 0, 4, 8 queued while txready is low.
        enable_b = 1'b1;
        step();
        peak = '0;
        for (int i = 0; i < 12; i++) begin
            tick_b(8'(i));
            @(negedge clk);
            if (level_b > peak) peak = level_b;
        end
        check("decim_peak",  {27'd0, peak}, 3);
        check("decim_level", {27'd0, level_b}, 3);
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'h04);
        exp_b.push_back(8'h08);
        hold_b = 1'b0;
        drain_b("decim");

        // Basic frame and SYNC latency.
        enable_a = 1'b1;
        step();
        exp_a.push_back(8'hA5);
        exp_a.push_back(8'h80);
        exp_a.push_back(8'h81);
        exp_a.push_back(8'hA5);
        exp_a.push_back(8'h82);
        tick_a(8'h80);
        @(negedge clk);
        check("latency_clk1", {31'd0, txclk_a}, 0);
        @(negedge clk);
        check("latency_clk2", {31'd0, txclk_a}, 1);
        step();
        tick_a(8'h81);
        tick_a(8'h82);
        drain_a("basic");

        // Overflow: 17 pushes into 16 entries with txready held low.
        toggle_a();
        hold_a = 1'b1;
        for (int i = 0; i < 17; i++) tick_a(8'h10 + 8'(i));
        @(negedge clk);
        check("ovf_level", {27'd0, level_a}, 16);
        check("ovf_flag",  {31'd0, overflow_a}, 1);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) exp_a.push_back(8'hA5);
            exp_a.push_back(8'h10 + 8'(i));
        end
        hold_a = 1'b0;
        drain_a("ovf");
        check("ovf_sticky", {31'd0, overflow_a}, 1);
        toggle_a();
        @(negedge clk);
        check("ovf_cleared", {31'd0, overflow_a}, 0);

        // Full FIFO: push coincides with the first data pop.
        hold_a = 1'b1;
        for (int i = 0; i < 16; i++) tick_a(8'h20 + 8'(i));
        @(negedge clk);
        check("full_level", {27'd0, level_a}, 16);
        check("full_ovf",   {31'd0, overflow_a}, 0);
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0) exp_a.push_back(8'hA5);
            exp_a.push_back((i < 16) ? 8'h20 + 8'(i) : 8'h5E);
        end
        hold_a = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (txclk_a && txdata_a != 8'hA5) found = 1'b1;
        end
        check("full_pop_seen", {31'd0, found}, 1);
        sample_in_a = 8'h5E;
        tick_a_s    = 1'b1;
        step();
        tick_a_s    = 1'b0;
        @(negedge clk);
        check("full_pushpop_level", {27'd0, level_a}, 16);
        check("full_pushpop_ovf",   {31'd0, overflow_a}, 0);
        drain_a("full");
        check("full_end_ovf", {31'd0, overflow_a}, 0);

        // Enable drop mid-byte: in-flight byte completes, backlog is flushed.
        toggle_a();
        hold_a = 1'b1;
        for (int i = 0; i < 5; i++) tick_a(8'h30 + 8'(i));
        @(negedge clk);
        check("edrop_level_before", {27'd0, level_a}, 5);
        exp_a.push_back(8'hA5);
        hold_a = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (txclk_a) found = 1'b1;
        end
        check("edrop_send_seen", {31'd0, found}, 1);
        step();
        enable_a = 1'b0;
        drain_a("edrop");
        check("edrop_level_after", {27'd0, level_a}, 0);
        enable_a = 1'b1;
        step();
        exp_a.push_back(8'hA5);
        exp_a.push_back(8'h77);
        tick_a(8'h77);
        drain_a("reenable");

        // Reset asserted during the SEND cycle.
        toggle_a();
        exp_a.push_back(8'hA5);
        tick_a(8'h66);
        step();
        check("rst_in_send", {31'd0, txclk_a}, 1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        @(negedge clk);
        check("midrst_txclk",  {31'd0, txclk_a}, 0);
        check("midrst_txdata", {24'd0, txdata_a}, 0);
        check("midrst_level",  {27'd0, level_a}, 0);
        check("midrst_busy",   {31'd0, busy_a}, 0);
        repeat (10) step();
        check("midrst_queue", exp_a.size(), 0);
        check("midrst_quiet", {31'd0, busy_a}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
